// File: rtl/nios_pio_ext_pkg.sv
// -----------------------------------------------------------------------------
// nios_pio_ext_pkg
// Shared constants for the extended parallel I/O peripheral:
//   - register word addresses on the Avalon-MM slave (3-bit)
//   - edge-capture mode selectors for the EDGE_TYPE parameter
// -----------------------------------------------------------------------------
package nios_pio_ext_pkg;

  // Register map (word addresses)
  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  // Edge-capture modes
  localparam int EDGE_RISE = 32'sd0;
  localparam int EDGE_FALL = 32'sd1;
  localparam int EDGE_ANY  = 32'sd2;

endpackage

// File: rtl/nios_pio_sync_edge.sv
// -----------------------------------------------------------------------------
// nios_pio_sync_edge
// Brings asynchronous pin inputs into the clk domain and flags edges.
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   pin_i    in   DATA_WIDTH asynchronous pin inputs
//   sync_o   out  DATA_WIDTH synchronized pin levels (second flop)
//   edge_o   out  DATA_WIDTH one-cycle edge flags, selected by EDGE_TYPE,
//                 held at zero until the post-reset arm counter saturates
// -----------------------------------------------------------------------------
module nios_pio_sync_edge
  import nios_pio_ext_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int EDGE_TYPE  = EDGE_RISE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] pin_i,
  output logic [DATA_WIDTH-1:0] sync_o,
  output logic [DATA_WIDTH-1:0] edge_o
);

  logic [DATA_WIDTH-1:0] sync1_q;
  logic [DATA_WIDTH-1:0] sync2_q;
  logic [DATA_WIDTH-1:0] prev_q;
  logic [1:0]            arm_q;
  logic [1:0]            arm_d;
  logic [DATA_WIDTH-1:0] rise_s;
  logic [DATA_WIDTH-1:0] fall_s;
  logic [DATA_WIDTH-1:0] sel_s;

  // Synchronizer chain, previous-level register and arm counter state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      arm_q   <= 2'd0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      arm_q   <= arm_d;
    end
  end

  // Arm counter saturates at 3; by then prev holds the real pin level, so
  // pins that were already high during reset do not look like a rising edge.
  always_comb begin
    arm_d = arm_q;
    if (arm_q != 2'd3) begin
      arm_d = arm_q + 2'd1;
    end else begin
      arm_d = arm_q;
    end
  end

  // Edge selection and arm gating.
  always_comb begin
    rise_s = sync2_q & ~prev_q;
    fall_s = ~sync2_q & prev_q;
    sel_s  = '0;
    case (EDGE_TYPE)
      EDGE_RISE: sel_s = rise_s;
      EDGE_FALL: sel_s = fall_s;
      EDGE_ANY:  sel_s = rise_s | fall_s;
      default:   sel_s = rise_s;
    endcase
    if (arm_q == 2'd3) begin
      edge_o = sel_s;
    end else begin
      edge_o = '0;
    end
  end

  assign sync_o = sync2_q;

endmodule

// File: rtl/nios_pio_ext.sv
// -----------------------------------------------------------------------------
// nios_pio_ext
// Bidirectional parallel I/O with per-bit direction, atomic set/clear writes,
// sticky edge capture and a maskable level interrupt. Avalon-MM slave.
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   address     in   3-bit register word select
//   chipselect  in   slave select
//   write_n     in   active-low write strobe
//   writedata   in   32-bit write data (bits above DATA_WIDTH ignored)
//   readdata    out  32-bit combinational read data, zero-extended
//   in_port     in   DATA_WIDTH asynchronous pin inputs
//   out_port    out  DATA_WIDTH output data register
//   oe_port     out  DATA_WIDTH per-bit output enable (direction register)
//   irq         out  registered active-high level interrupt
// -----------------------------------------------------------------------------
module nios_pio_ext
  import nios_pio_ext_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_OUT  = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_DIR  = '0,
  parameter int                    EDGE_TYPE  = EDGE_RISE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] oe_port,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [DATA_WIDTH-1:0] dir_q, dir_d;
  logic [DATA_WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [DATA_WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic                  irq_q, irq_d;

  logic                  we_s;
  logic [DATA_WIDTH-1:0] wd_s;
  logic [DATA_WIDTH-1:0] clr_s;
  logic [DATA_WIDTH-1:0] sync_s;
  logic [DATA_WIDTH-1:0] edge_s;
  logic [DATA_WIDTH-1:0] rd_s;

  assign we_s = chipselect & ~write_n;
  assign wd_s = writedata[DATA_WIDTH-1:0];

  generate
    if (DATA_WIDTH < 32) begin : g_wd_pad
      // Upper write-data bits have no register behind them.
      logic unused_wd_s;
      assign unused_wd_s = ^writedata[31:DATA_WIDTH];
    end
  endgenerate

  nios_pio_sync_edge #(
    .DATA_WIDTH (DATA_WIDTH),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .pin_i   (in_port),
    .sync_o  (sync_s),
    .edge_o  (edge_s)
  );

  // Register-file next state from bus writes.
  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    irq_mask_d = irq_mask_q;
    clr_s      = '0;
    if (we_s) begin
      case (address)
        ADDR_DATA:    data_out_d = wd_s;
        ADDR_DIR:     dir_d      = wd_s;
        ADDR_IRQMASK: irq_mask_d = wd_s;
        ADDR_EDGECAP: clr_s      = wd_s;
        ADDR_OUTSET:  data_out_d = data_out_q | wd_s;
        ADDR_OUTCLR:  data_out_d = data_out_q & ~wd_s;
        default:      clr_s      = '0;
      endcase
    end else begin
      clr_s = '0;
    end
  end

  // Sticky capture: OR-ing the new edge after the clear makes set win a
  // same-cycle collision. irq looks at the next capture value so it rises
  // together with the capture bit.
  always_comb begin
    edge_cap_d = (edge_cap_q & ~clr_s) | edge_s;
    irq_d      = |(edge_cap_d & irq_mask_q);
  end

  // Register file and interrupt state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= RESET_OUT;
      dir_q      <= RESET_DIR;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      irq_q      <= irq_d;
    end
  end

  // Zero-wait-state read mux; DATA shows driven bits from the register and
  // input bits from the synchronized pins.
  always_comb begin
    rd_s = '0;
    case (address)
      ADDR_DATA:    rd_s = (dir_q & data_out_q) | (~dir_q & sync_s);
      ADDR_DIR:     rd_s = dir_q;
      ADDR_IRQMASK: rd_s = irq_mask_q;
      ADDR_EDGECAP: rd_s = edge_cap_q;
      default:      rd_s = '0;
    endcase
    readdata = 32'h0000_0000;
    if (chipselect) begin
      readdata[DATA_WIDTH-1:0] = rd_s;
    end else begin
      readdata = 32'h0000_0000;
    end
  end

  assign out_port = data_out_q;
  assign oe_port  = dir_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_nios_pio_ext.sv
module tb_nios_pio_ext;
  import nios_pio_ext_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [7:0]  in_port = 8'h00;
  logic [31:0] rd, rd_any;
  logic [7:0]  out_port, oe_port, out_any, oe_any;
  logic        irq, irq_any;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  nios_pio_ext #(.DATA_WIDTH(8), .RESET_OUT(8'hA5), .RESET_DIR(8'h0F), .EDGE_TYPE(EDGE_RISE)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd), .in_port(in_port),
    .out_port(out_port), .oe_port(oe_port), .irq(irq));

  nios_pio_ext #(.DATA_WIDTH(8), .RESET_OUT(8'hA5), .RESET_DIR(8'h0F), .EDGE_TYPE(EDGE_ANY)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_any), .in_port(in_port),
    .out_port(out_any), .oe_port(oe_any), .irq(irq_any));

  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
  endtask

  task automatic bus_read(input logic [2:0] a);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_port = 8'h00;
    repeat (3) tick();
    reset_n = 1'b1;
    exp_q.push_back(32'hA5); exp_q.push_back(32'h0F); exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);  exp_q.push_back(32'h0);  exp_q.push_back(32'h05);
    tick();
    exp_v = exp_q.pop_front(); checks++;
    if (out_port !== exp_v[7:0]) begin failures++; $display("FAIL reset_out got=%h exp=%h", out_port, exp_v[7:0]); end
    exp_v = exp_q.pop_front(); checks++;
    if (oe_port !== exp_v[7:0]) begin failures++; $display("FAIL reset_oe got=%h exp=%h", oe_port, exp_v[7:0]); end
    exp_v = exp_q.pop_front(); checks++;
    if (irq !== exp_v[0]) begin failures++; $display("FAIL reset_irq got=%b exp=%b", irq, exp_v[0]); end
    bus_read(ADDR_IRQMASK);
    exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin failures++; $display("FAIL reset_mask got=%h exp=%h", rd, exp_v); end
    bus_read(ADDR_EDGECAP);
    exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin failures++; $display("FAIL reset_edgecap got=%h exp=%h", rd, exp_v); end
    bus_read(ADDR_DATA);
    exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin failures++; $display("FAIL reset_data got=%h exp=%h", rd, exp_v); end
  endtask

  task automatic test_set_clear();
    exp_q.push_back(32'h0F); exp_q.push_back(32'h3F); exp_q.push_back(32'h3C);
    exp_q.push_back(32'h0);  exp_q.push_back(32'h0);  exp_q.push_back(32'h3C);
    exp_q.push_back(32'h0);
    bus_write(ADDR_DATA, 32'h0000_000F);
    exp_v = exp_q.pop_front(); checks++;
    if (out_port !== exp_v[7:0]) begin failures++; $display("FAIL data_write got=%h exp=%h", out_port, exp_v[7:0]); end
    bus_write(ADDR_OUTSET, 32'hFFFF_0030);
    exp_v = exp_q.pop_front(); checks++;
    if (out_port !== exp_v[7:0]) begin failures++; $display("FAIL outset got=%h exp=%h", out_port, exp_v[7:0]); end
    bus_write(ADDR_OUTCLR, 32'h0000_0003);
    exp_v = exp_q.pop_front(); checks++;
    if (out_port !== exp_v[7:0]) begin failures++; $display("FAIL outclr got=%h exp=%h", out_port, exp_v[7:0]); end
    bus_read(ADDR_OUTSET);
    exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin failures++; $display("FAIL read_outset got=%h exp=%h", rd, exp_v); end
    bus_read(ADDR_OUTCLR);
    exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin failures++; $display("FAIL read_outclr got=%h exp=%h", rd, exp_v); end
    bus_write(3'd6, 32'h0000_00FF);
    exp_v = exp_q.pop_front(); checks++;
    if (out_port !== exp_v[7:0]) begin failures++; $display("FAIL addr6_write got=%h exp=%h", out_port, exp_v[7:0]); end
    bus_read(3'd6);
    exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin failures++; $display("FAIL read_addr6 got=%h exp=%h", rd, exp_v); end
  endtask

  task automatic test_read_mux();
    exp_q.push_back(32'hA5); exp_q.push_back(32'hF0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    bus_write(ADDR_DIR, 32'h0000_00F0);
    bus_write(ADDR_DATA, 32'h0000_00A0);
    in_port = 8'h05;
    repeat (2) tick();
    bus_read(ADDR_DATA);
    exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin failures++; $display("FAIL data_mux got=%h exp=%h", rd, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (oe_port !== exp_v[7:0]) begin failures++; $display("FAIL oe_dir got=%h exp=%h", oe_port, exp_v[7:0]); end
    tick();
    bus_write(ADDR_EDGECAP, 32'h0000_00FF);
    bus_read(ADDR_EDGECAP);
    exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin failures++; $display("FAIL clear_all got=%h exp=%h", rd, exp_v); end
    in_port = 8'h00;
    repeat (4) tick();
    bus_read(ADDR_EDGECAP);
    exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin failures++; $display("FAIL fall_ignored got=%h exp=%h", rd, exp_v); end
  endtask

  task automatic test_edge_irq();
    exp_q.push_back(32'h01);
    exp_q.push_back(32'h00); exp_q.push_back(32'h0);
    exp_q.push_back(32'h01); exp_q.push_back(32'h1);
    exp_q.push_back(32'h01);
    exp_q.push_back(32'h03); exp_q.push_back(32'h1);
    exp_q.push_back(32'h02); exp_q.push_back(32'h0);
    bus_write(ADDR_IRQMASK, 32'h0000_0001);
    bus_read(ADDR_IRQMASK);
    exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin failures++; $display("FAIL mask_readback got=%h exp=%h", rd, exp_v); end
    in_port = 8'h01;
    repeat (2) tick();
    bus_read(ADDR_EDGECAP);
    exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin failures++; $display("FAIL cap_early got=%h exp=%h", rd, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (irq !== exp_v[0]) begin failures++; $display("FAIL irq_early got=%b exp=%b", irq, exp_v[0]); end
    tick();
    bus_read(ADDR_EDGECAP);
    exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin failures++; $display("FAIL cap_latency got=%h exp=%h", rd, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (irq !== exp_v[0]) begin failures++; $display("FAIL irq_latency got=%b exp=%b", irq, exp_v[0]); end
    in_port = 8'h00;
    repeat (4) tick();
    bus_read(ADDR_EDGECAP);
    exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin failures++; $display("FAIL cap_after_fall got=%h exp=%h", rd, exp_v); end
    in_port = 8'h02;
    repeat (3) tick();
    bus_read(ADDR_EDGECAP);
    exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin failures++; $display("FAIL cap_bit1 got=%h exp=%h", rd, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (irq !== exp_v[0]) begin failures++; $display("FAIL irq_bit1 got=%b exp=%b", irq, exp_v[0]); end
    bus_write(ADDR_EDGECAP, 32'h0000_0001);
    bus_read(ADDR_EDGECAP);
    exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin failures++; $display("FAIL clr_bit0 got=%h exp=%h", rd, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (irq !== exp_v[0]) begin failures++; $display("FAIL irq_unmasked got=%b exp=%b", irq, exp_v[0]); end
  endtask

  task automatic test_clear_collision();
    exp_q.push_back(32'h03); exp_q.push_back(32'h1);
    exp_q.push_back(32'h02); exp_q.push_back(32'h0);
    exp_q.push_back(32'h02); exp_q.push_back(32'h1);
    exp_q.push_back(32'h00); exp_q.push_back(32'h0);
    in_port = 8'h03;
    repeat (2) tick();
    bus_write(ADDR_EDGECAP, 32'h0000_0001);
    bus_read(ADDR_EDGECAP);
    exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin failures++; $display("FAIL collision_cap got=%h exp=%h", rd, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (irq !== exp_v[0]) begin failures++; $display("FAIL collision_irq got=%b exp=%b", irq, exp_v[0]); end
    tick();
    bus_write(ADDR_EDGECAP, 32'h0000_0001);
    bus_read(ADDR_EDGECAP);
    exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin failures++; $display("FAIL late_clear got=%h exp=%h", rd, exp_v); end
    tick();
    exp_v = exp_q.pop_front(); checks++;
    if (irq !== exp_v[0]) begin failures++; $display("FAIL irq_drop got=%b exp=%b", irq, exp_v[0]); end
    bus_write(ADDR_EDGECAP, 32'h0000_0000);
    bus_read(ADDR_EDGECAP);
    exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin failures++; $display("FAIL zero_clear got=%h exp=%h", rd, exp_v); end
    bus_write(ADDR_IRQMASK, 32'h0000_0002);
    tick();
    exp_v = exp_q.pop_front(); checks++;
    if (irq !== exp_v[0]) begin failures++; $display("FAIL irq_mask_bit1 got=%b exp=%b", irq, exp_v[0]); end
    bus_write(ADDR_EDGECAP, 32'h0000_00FF);
    tick();
    bus_read(ADDR_EDGECAP);
    exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin failures++; $display("FAIL clear_rest got=%h exp=%h", rd, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (irq !== exp_v[0]) begin failures++; $display("FAIL irq_final got=%b exp=%b", irq, exp_v[0]); end
  endtask

  task automatic test_reset_arming();
    exp_q.push_back(32'hA5); exp_q.push_back(32'h0F);
    in_port = 8'hFF;
    reset_n = 1'b0;
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (out_port !== exp_v[7:0]) begin failures++; $display("FAIL midreset_out got=%h exp=%h", out_port, exp_v[7:0]); end
    exp_v = exp_q.pop_front(); checks++;
    if (oe_port !== exp_v[7:0]) begin failures++; $display("FAIL midreset_oe got=%h exp=%h", oe_port, exp_v[7:0]); end
    repeat (3) tick();
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      tick();
      bus_read(ADDR_EDGECAP);
      exp_v = exp_q.pop_front(); checks++;
      if (rd_any !== exp_v) begin failures++; $display("FAIL arm_any cycle=%0d got=%h exp=%h", i, rd_any, exp_v); end
      exp_v = exp_q.pop_front(); checks++;
      if (rd !== exp_v) begin failures++; $display("FAIL arm_rise cycle=%0d got=%h exp=%h", i, rd, exp_v); end
    end
    exp_q.push_back(32'h08); exp_q.push_back(32'h08); exp_q.push_back(32'h08);
    in_port = 8'hF7;
    repeat (3) tick();
    bus_read(ADDR_EDGECAP);
    exp_v = exp_q.pop_front(); checks++;
    if (rd_any !== exp_v) begin failures++; $display("FAIL any_fall got=%h exp=%h", rd_any, exp_v); end
    in_port = 8'hFF;
    repeat (3) tick();
    bus_read(ADDR_EDGECAP);
    exp_v = exp_q.pop_front(); checks++;
    if (rd_any !== exp_v) begin failures++; $display("FAIL any_pulse got=%h exp=%h", rd_any, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin failures++; $display("FAIL rise_pulse got=%h exp=%h", rd, exp_v); end
  endtask

  initial begin
    test_reset();
    test_set_clear();
    test_read_mux();
    test_edge_irq();
    test_clear_collision();
    test_reset_arming();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nios_pio_ext.md
Name: nios_pio_ext

Overview:
- Parametrised bidirectional parallel I/O peripheral; Avalon-MM slave on the Nios II system bus. Successor to the fixed 8-bit output-only PIO.
- Provides per-bit direction control and atomic set/clear writes.
- Inputs pass through a 2-stage synchronizer into edge detection, latched edge-capture bits and a maskable level interrupt to the CPU.

Parameters:
- DATA_WIDTH, 8, port width in bits; legal range 1..32.
- RESET_OUT, 0, reset value of the output data register; DATA_WIDTH bits.
- RESET_DIR, 0, reset value of the direction register; 1 = output.
- EDGE_TYPE, 0, capture mode: 0 = rising, 1 = falling, 2 = any edge.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous assert, active-low
- address  in  3  register word select
- chipselect  in  1  slave select
- write_n  in  1  write strobe, active-low
- writedata  in  32  write data; bits above DATA_WIDTH ignored
- readdata  out  32  read data; combinational, zero wait states; upper bits zero
- in_port  in  DATA_WIDTH  asynchronous pin inputs
- out_port  out  DATA_WIDTH  output data register
- oe_port  out  DATA_WIDTH  per-bit output enable; equals direction register
- irq  out  1  level interrupt, active-high

Behaviour:
- Reset: clk is clk; reset_n is asynchronous, active-low.
  - Values during reset: data_out = RESET_OUT; dir = RESET_DIR; irq_mask = 0; edge_cap = 0; sync stages and prev = 0; arm counter = 0; irq = 0.
- Write: occurs on a rising clk edge when chipselect = 1 and write_n = 0. Register map by address:
  - 0 DATA: write sets data_out = wd. Read returns per bit dir ? data_out : sync2.
  - 1 DIR: read/write.
  - 2 IRQMASK: read/write.
  - 3 EDGECAP: read returns edge_cap. A write clears every bit where wd = 1 (write-1-to-clear).
  - 4 OUTSET: write sets data_out |= wd. Read returns 0.
  - 5 OUTCLR: write sets data_out &= ~wd. Read returns 0.
  - 6, 7: reads return 0; writes are ignored.
- readdata is valid in the same cycle as address and chipselect. Reads have no side effects.
- Input path:
  - in_port -> sync1 -> sync2 (2-FF synchronizer).
  - prev <= sync2 each cycle.
  - Edge detect: rise = sync2 & ~prev; fall = ~sync2 & prev; select by EDGE_TYPE.
- Latency: a pin changing before clk edge k gives sync1 at k and sync2 at k+1. The edge_cap bit and irq are visible after edge k+2 (3 cycles).
- Post-reset arming: a 2-bit arm counter saturates at 3 after reset release. Edge detection is gated off until the counter = 3, so pins held high at reset produce no spurious capture.
- Edge capture is sticky per bit and is captured regardless of dir or irq_mask.
  - Simultaneous clear write and new edge on the same bit: set wins, bit stays 1.
  - Clear writes with wd = 0 bits leave those bits unchanged.
- irq is registered: irq <= |(edge_cap_next & irq_mask). It deasserts the cycle after the clear or mask write takes effect.
- Reset mid-operation: all state returns immediately to reset values; the arm sequence restarts.

Decomposition:
- Package nios_pio_ext_pkg holds:
  - Address constants ADDR_DATA..ADDR_OUTCLR (3-bit).
  - EDGE_RISE/EDGE_FALL/EDGE_ANY constants.
- One sub-module, nios_pio_sync_edge: DATA_WIDTH-wide 2-FF synchronizer, prev register, arm counter and edge-detect output. The top level holds the register file, read mux and irq.

Test Plan:
- Reset defaults: RESET_OUT = 8'hA5, RESET_DIR = 8'h0F. Release reset -> out_port = A5, oe_port = 0F, irq = 0. Read addr 2 -> 0, addr 3 -> 0.
- Set/clear: write DATA = 8'h0F, then OUTSET = 8'h30, then OUTCLR = 8'h03. Expect out_port = 0F, 3F, 3C after the respective edges. Reads of addr 4/5 return 0.
- Data read mux: dir = 8'hF0, data_out = 8'hA0, in_port = 8'h05. Read addr 0 -> 8'hA5 (valid ≥2 cycles after in_port settles).
- Edge/irq latency, EDGE_TYPE = 0, mask = 8'h01: in_port[0] 0->1 before edge k -> edge_cap = 01 and irq = 1 after edge k+2. A 1->0 transition captures nothing. An unmasked bit 1 rise -> edge_cap = 03, irq stays driven by bit 0 only.
- Clear collision: write EDGECAP = 8'h01 in the same cycle a new rise on bit 0 is detected -> edge_cap[0] stays 1, irq stays 1. A later clear with no edge -> 0, and irq = 0 one cycle later.
- Reset arming: hold in_port = 8'hFF through reset, release -> edge_cap stays 0 for ≥10 cycles. Then pulse bit 3 low then high with EDGE_TYPE = 2 -> edge_cap = 8'h08.
